axis_flit_injector: RTL



---
 rtl/noc_pkg.sv | 27 ++
 rtl/noc_credit_counter.sv | 54 +++++
 rtl/axis_flit_injector.sv | 132 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: credit-counter sizing, the holding-register state
// encoding and the flit bundle used on router local ports.
package noc_pkg;

   // Bits needed to hold any credit count from 0 up to and including depth.
   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Holding register of an injection stage: empty, or loaded with a beat.
   typedef enum logic {
      HOLD_EMPTY  = 1'b0,
      HOLD_LOADED = 1'b1
   } hold_state_e;

   // Flit bundle at the default NoC widths. Blocks built with other widths
   // declare a bundle of the same shape from their own parameters.
   localparam int NOC_FLIT_W = 32;
   localparam int NOC_DEST_W = 6;

   typedef struct packed {
      logic [NOC_FLIT_W-1:0] data;
      logic [NOC_DEST_W-1:0] dest;
      logic                  is_tail;
   } flit_t;

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for credit-based links: starts full, decrements on each
// flit sent, increments on each credit returned, saturates at DEPTH and
// raises a sticky overflow flag if a credit arrives while already full.
module noc_credit_counter
   import noc_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = credit_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             err_overflow
);

   localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(DEPTH);

   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;

   // Next count: simultaneous inc and dec cancel; a surplus credit saturates.
   always_comb begin
      // NOTE: every variable gets its default before the case, so no path
      // leaves it unassigned and no latch is inferred.
      count_d = count_q;
      err_d   = err_q;
      unique case ({inc, dec})
         2'b10: begin
            if (count_q == MAX_COUNT) err_d = 1'b1;
            else                      count_d = count_q + CNT_W'(1);
         end
         2'b01:   count_d = count_q - CNT_W'(1);
         default: ;
      endcase
   end

   // Count and sticky flag registers; reset returns the link to full credit.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         count_q <= MAX_COUNT;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign count        = count_q;
   assign err_overflow = err_q;

endmodule

// File: rtl/axis_flit_injector.sv
// AXI-Stream to router local-port injector. Each accepted beat is held and
// sent as SERIALIZATION_FACTOR flits, least-significant slice first, one per
// cycle while the downstream buffer has credit.
module axis_flit_injector
   import noc_pkg::*;
#(
   parameter int TDATA_WIDTH          = 128,
   parameter int DEST_WIDTH           = 6,
   parameter int SERIALIZATION_FACTOR = 4,
   parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
   parameter int FLIT_BUFFER_DEPTH    = 8
) (
   input  logic                                    clk_noc,
   input  logic                                    rst_n,
   input  logic                                    axis_tvalid,
   output logic                                    axis_tready,
   input  logic [TDATA_WIDTH-1:0]                  axis_tdata,
   input  logic                                    axis_tlast,
   input  logic [DEST_WIDTH-1:0]                   axis_tdest,
   output logic [FLIT_WIDTH-1:0]                   data_out,
   output logic [DEST_WIDTH-1:0]                   dest_out,
   output logic                                    is_tail_out,
   output logic                                    send_out,
   input  logic                                    credit_in,
   output logic [credit_w(FLIT_BUFFER_DEPTH)-1:0]  credit_count,
   output logic                                    err_credit_overflow
);

   localparam int              IDX_W    = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);

   typedef struct packed {
      logic [FLIT_WIDTH-1:0] data;
      logic [DEST_WIDTH-1:0] dest;
      logic                  is_tail;
   } out_flit_t;

   hold_state_e            state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [TDATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic [DEST_WIDTH-1:0]  hold_dest_q, hold_dest_d;
   logic                   hold_last_q, hold_last_d;
   out_flit_t              flit_q, flit_d;
   logic                   send_q, send_d;
   logic                   ready_en_q, ready_en_d;

   logic hold_valid;
   logic at_last;
   logic emit;
   logic accept;

   // Emit depends only on registered state, never on credit_in directly.
   assign hold_valid  = (state_q == HOLD_LOADED);
   assign at_last     = (idx_q == LAST_IDX);
   assign emit        = hold_valid && (credit_count != '0);
   // A beat may load while the last slice of the previous one leaves.
   assign axis_tready = ready_en_q && (!hold_valid || (emit && at_last));
   assign accept      = axis_tvalid && axis_tready;

   // Next-state for the holding register, slice index and output flit.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      hold_data_d = hold_data_q;
      hold_dest_d = hold_dest_q;
      hold_last_d = hold_last_q;
      flit_d      = flit_q;
      send_d      = 1'b0;
      ready_en_d  = 1'b1;
      if (emit) begin
         flit_d.data    = hold_data_q[int'(idx_q)*FLIT_WIDTH +: FLIT_WIDTH];
         flit_d.dest    = hold_dest_q;
         flit_d.is_tail = hold_last_q && at_last;
         send_d         = 1'b1;
         if (at_last) begin
            idx_d   = '0;
            state_d = HOLD_EMPTY;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
      if (accept) begin
         hold_data_d = axis_tdata;
         hold_dest_d = axis_tdest;
         hold_last_d = axis_tlast;
         idx_d       = '0;
         state_d     = HOLD_LOADED;
      end
   end

   // State registers; reset discards any held beat and partial flits.
   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HOLD_EMPTY;
         idx_q       <= '0;
         // NOTE: the payload register is reset as well, so no output ever
         // carries X after reset.
         hold_data_q <= '0;
         hold_dest_q <= '0;
         hold_last_q <= 1'b0;
         flit_q      <= '0;
         send_q      <= 1'b0;
         ready_en_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         hold_data_q <= hold_data_d;
         hold_dest_q <= hold_dest_d;
         hold_last_q <= hold_last_d;
         flit_q      <= flit_d;
         send_q      <= send_d;
         ready_en_q  <= ready_en_d;
      end
   end

   noc_credit_counter #(
      .DEPTH (FLIT_BUFFER_DEPTH)
   ) u_credit (
      .clk          (clk_noc),
      .rst_n        (rst_n),
      .inc          (credit_in),
      .dec          (emit),
      .count        (credit_count),
      .err_overflow (err_credit_overflow)
   );

   assign data_out    = flit_q.data;
   assign dest_out    = flit_q.dest;
   assign is_tail_out = flit_q.is_tail;
   assign send_out    = send_q;

endmodule
